// File: rtl/trg_arb_pkg.sv
// Shared types for the trigger source arbiter: FSM states, source codes,
// default sizing and small combinational helpers.
package trg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    DEAD      = 2'd2,
    WAIT_BUSY = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE    = 2'd0,
    SRC_COINCID = 2'd1,
    SRC_EXT     = 2'd2,
    SRC_CYCLED  = 2'd3
  } trg_src_e;

  localparam int DEAD_UNIT_DEF = 50;
  localparam int CNT_W_DEF     = 16;

  function automatic logic [1:0] cand_count(input logic [2:0] cand);
    return {1'b0, cand[0]} + {1'b0, cand[1]} + {1'b0, cand[2]};
  endfunction

  // Fixed priority: coincidence beats external beats cycled.
  function automatic trg_src_e pick_winner(input logic [2:0] cand);
    if (cand[0])      return SRC_COINCID;
    else if (cand[1]) return SRC_EXT;
    else if (cand[2]) return SRC_CYCLED;
    else              return SRC_NONE;
  endfunction

endpackage

// File: rtl/trg_edge_det.sv
// Registered rising-edge detector, one independent bit per input.
module trg_edge_det #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] prev_q;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      always_ff @(posedge clk_i) begin
        if (rst_i) prev_q[gi] <= 1'b0;
        else       prev_q[gi] <= d_i[gi];
      end
      assign rise_o[gi] = d_i[gi] & ~prev_q[gi];
    end
  endgenerate

endmodule

// File: rtl/trg_src_arbiter.sv
// Trigger front-end: edge detect, fixed-priority arbitration, busy/dead-time
// gating and effective/lost counters. Optional coincidence prescaler: TRG_PRESCALE_EN.
module trg_src_arbiter
  import trg_arb_pkg::*;
#(
  parameter int DEAD_UNIT = DEAD_UNIT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             coincid_trg_in,
  input  logic             ext_trg_syn_in,
  input  logic             cycled_trg_in,
  input  logic [2:0]       src_enb_in,
  input  logic             trg_enb_in,
  input  logic [1:0]       busy_syn_in,
  input  logic             pmu_busy_in,
  input  logic             busy_ignore_in,
  input  logic [7:0]       trg_dead_time_in,
`ifdef TRG_PRESCALE_EN
  input  logic [7:0]       prescale_in,
`endif
  input  logic             cnt_clr_in,
  output logic             trg_req_out,
  output logic [1:0]       trg_src_out,
  output logic [CNT_W-1:0] eff_trg_cnt_out,
  output logic [CNT_W-1:0] lost_trg_cnt_out,
  output logic             arb_busy_out
);

  localparam int DW = 8 + $clog2(DEAD_UNIT + 1);

  logic [2:0]       rise_w;
  logic [2:0]       cand_raw;
  logic [2:0]       cand;
  logic             busy_any;
  logic [DW-1:0]    dead_load;
  trg_src_e         winner;
  logic             start;
  logic             eff_inc;
  logic [1:0]       lost_inc;
  logic [CNT_W:0]   eff_sum;
  logic [CNT_W+1:0] lost_sum;

  arb_state_e       state_q;
  logic [DW-1:0]    dead_q;
  logic             req_q;
  logic [1:0]       src_q;
  logic             arb_busy_q;
  logic [CNT_W-1:0] eff_q;
  logic [CNT_W-1:0] lost_q;

  trg_edge_det #(.W(3)) u_edge_det (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .d_i    ({cycled_trg_in, ext_trg_syn_in, coincid_trg_in}),
    .rise_o (rise_w)
  );

  assign cand_raw = rise_w & src_enb_in & {3{trg_enb_in}};

`ifdef TRG_PRESCALE_EN
  logic [7:0] presc_q;

  // Only every (prescale_in+1)-th coincidence candidate survives; the rest vanish uncounted.
  always_ff @(posedge clk_in) begin
    if (rst_in || cnt_clr_in) presc_q <= 8'd0;
    else if (cand_raw[0])     presc_q <= (presc_q >= prescale_in) ? 8'd0 : presc_q + 8'd1;
  end

  assign cand = {cand_raw[2:1], cand_raw[0] & (presc_q >= prescale_in)};
`else
  assign cand = cand_raw;
`endif

  assign busy_any  = ((|busy_syn_in) | pmu_busy_in) & ~busy_ignore_in;
  assign dead_load = DW'(trg_dead_time_in) * DW'(DEAD_UNIT);
  assign winner    = pick_winner(cand);

  always_comb begin
    start    = 1'b0;
    eff_inc  = 1'b0;
    lost_inc = cand_count(cand);
    if (state_q == IDLE && cand != 3'b000 && !busy_any) begin
      start    = 1'b1;
      eff_inc  = 1'b1;
      lost_inc = cand_count(cand) - 2'd1;
    end
  end

  assign eff_sum  = {1'b0, eff_q} + {{CNT_W{1'b0}}, eff_inc};
  assign lost_sum = {2'b00, lost_q} + {{CNT_W{1'b0}}, lost_inc};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      dead_q     <= '0;
      req_q      <= 1'b0;
      src_q      <= SRC_NONE;
      arb_busy_q <= 1'b0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ISSUE;
            req_q      <= 1'b1;
            src_q      <= winner;
            arb_busy_q <= 1'b1;
          end
        end
        ISSUE: begin
          state_q <= DEAD;
          dead_q  <= dead_load;
        end
        DEAD: begin
          if (dead_q == '0) state_q <= WAIT_BUSY;
          else              dead_q  <= dead_q - DW'(1);
        end
        WAIT_BUSY: begin
          if (!busy_any) begin
            state_q    <= IDLE;
            arb_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          arb_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Counters saturate; a clear wins over any increment in the same cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in || cnt_clr_in) begin
      eff_q  <= '0;
      lost_q <= '0;
    end else begin
      eff_q  <= eff_sum[CNT_W] ? {CNT_W{1'b1}} : eff_sum[CNT_W-1:0];
      lost_q <= (|lost_sum[CNT_W+1:CNT_W]) ? {CNT_W{1'b1}} : lost_sum[CNT_W-1:0];
    end
  end

  assign trg_req_out      = req_q;
  assign trg_src_out      = src_q;
  assign eff_trg_cnt_out  = eff_q;
  assign lost_trg_cnt_out = lost_q;
  assign arb_busy_out     = arb_busy_q;

endmodule

// File: doc/trg_src_arbiter.md
Name: trg_src_arbiter

Overview:
- Front-end scheduler for the trigger output controller.
- Edge-detects the three trigger sources (coincidence, external, cycled) and arbitrates them by fixed priority.
- Gates each candidate with the global enable, per-source enables, detector busy and a programmable dead time.
- Emits one qualified trigger pulse with a source tag, plus the effective and lost trigger counts that feed downstream trigger-ID logic.

Parameters:
- DEAD_UNIT, 50, clock cycles per LSB of trg_dead_time_in (1 us at 50 MHz).
- CNT_W, 16, width of the effective and lost counters.

Ports:
- clk_in  in  1  system clock, 50 MHz.
- rst_in  in  1  reset; synchronous, active-high.
- coincid_trg_in  in  1  coincidence trigger level; pulse of ≥2 cycles.
- ext_trg_syn_in  in  1  external trigger, already synchronised.
- cycled_trg_in  in  1  periodic calibration trigger.
- src_enb_in  in  3  per-source enable: [0] coincid, [1] ext, [2] cycled.
- trg_enb_in  in  1  global trigger enable.
- busy_syn_in  in  2  synchronised Si busy flags.
- pmu_busy_in  in  1  PMU busy.
- busy_ignore_in  in  1  1 = ignore all busy inputs.
- trg_dead_time_in  in  8  dead time in DEAD_UNIT steps.
- cnt_clr_in  in  1  synchronous clear of both counters.
- trg_req_out  out  1  one-cycle qualified trigger.
- trg_src_out  out  2  source of last trigger: 1 coincid, 2 ext, 3 cycled, 0 none.
- eff_trg_cnt_out  out  CNT_W  accepted triggers.
- lost_trg_cnt_out  out  CNT_W  rejected triggers.
- arb_busy_out  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, edge registers 0, dead counter 0.
- Edge detect: edge = sampled input high while the previous sample was low. Held-high inputs produce exactly one edge.
- Qualification: an edge is a candidate only when trg_enb_in = 1 and its src_enb_in bit = 1. Other edges are discarded silently and do not count as lost.
- busy_any = (|busy_syn_in | pmu_busy_in) & ~busy_ignore_in.
- FSM states:
  - IDLE: a candidate with busy_any = 0 moves to ISSUE. A candidate with busy_any = 1 stays in IDLE and increments lost.
  - ISSUE (1 cycle): trg_req_out = 1, trg_src_out = winner, eff++, dead counter loaded with trg_dead_time_in*DEAD_UNIT. Next state DEAD.
  - DEAD: counter decrements each cycle; at 0 go to WAIT_BUSY. A load value of 0 gives one DEAD cycle.
  - WAIT_BUSY: when busy_any = 0, go to IDLE in the same cycle; otherwise hold.
- Latency: an input edge sampled at clock k gives trg_req_out high in cycle k+1 (ISSUE).
- Simultaneous candidates: priority coincid > ext > cycled. The winner is issued; each losing candidate increments lost, so up to +2 in one cycle.
- Candidates arriving in ISSUE, DEAD or WAIT_BUSY are not queued; each increments lost.
- Counters saturate at all-ones and never wrap.
- cnt_clr_in has priority over any increment in the same cycle.
- trg_src_out holds its value until the next ISSUE.
- trg_enb_in falling mid-operation: the current DEAD/WAIT_BUSY sequence completes normally.
- Dead-time product uses a width of 8 + clog2(DEAD_UNIT+1) bits and has no overflow.

Optional Feature:
- Macro TRG_PRESCALE_EN adds input prescale_in [7:0].
- With the macro: coincidence candidates pass through a modulo counter, and only every (prescale_in+1)-th coincid candidate is forwarded. Suppressed ones are not lost. The counter resets on rst_in and on cnt_clr_in.
- Without the macro: no port; every coincid candidate is forwarded.

Decomposition:
- Package trg_arb_pkg: FSM state encoding (IDLE, ISSUE, DEAD, WAIT_BUSY), source codes SRC_NONE/COINCID/EXT/CYCLED, default DEAD_UNIT.
- One sub-module, trg_edge_det: per-bit registered rising-edge detector, instantiated 3 bits wide.

Test Plan:
- Reset, then coincid high for 8 cycles with all enables set and busy_ignore_in = 0 → one trg_req_out pulse one cycle after the edge, trg_src_out = 1, eff = 1, lost = 0.
- trg_dead_time_in = 3, second ext edge 100 cycles after the first trigger → ext rejected (DEAD lasts 150 cycles), lost = 1. An edge at cycle 200 → accepted, trg_src_out = 2.
- All three edges in the same cycle → trg_src_out = 1, eff +1, lost +2.
- busy_syn_in[1] = 1 throughout, busy_ignore_in = 0 → edge lost. Set busy_ignore_in = 1 → next edge accepted.
- eff preset near saturation by 65535 triggers with dead time 0 → stays at 0xFFFF. cnt_clr_in together with an accepted trigger → both counters read 0.
- With TRG_PRESCALE_EN, prescale_in = 2 → 6 coincid edges produce exactly 2 triggers, lost = 0.
